// File: rtl/input_sequencer.sv
// Push-button/switch front end: shared sample tick, per-button sync + debounce + press pulse,
// and the stall/ack sequencer for the processor's input instruction.

module input_sequencer_lane #(
  parameter int STABLE_CNT = 3,
  parameter int CNT_W      = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic pulse
);
  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             s;

  assign s = sync[1];

  // Any tick sample that matches the current level restarts the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      pulse <= 1'b0;
      if (tick) begin
        if (s == level) begin
          cnt <= '0;
        end else if (cnt == CNT_W'(STABLE_CNT - 1)) begin
          level <= s;
          cnt   <= '0;
          pulse <= s;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

module input_sequencer #(
  parameter int N_BTN      = 4,
  parameter int DATA_W     = 16,
  parameter int TICK_DIV   = 250000,
  parameter int STABLE_CNT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTN-1:0]  btn_raw,
  input  logic [DATA_W-1:0] sw,
  input  logic              in_req,
  output logic              stall,
  output logic              in_ack,
  output logic [DATA_W-1:0] in_data,
  output logic [N_BTN-1:0]  btn_level,
  output logic [N_BTN-1:0]  btn_pulse
);
  localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W  = $clog2(STABLE_CNT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_REL, WAIT_PRESS, DONE} state_t;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  state_t            state, state_nxt;
  logic              capture;

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + 1'b1;
  end

  input_sequencer_lane #(.STABLE_CNT(STABLE_CNT), .CNT_W(CNT_W)) u_lane [N_BTN-1:0] (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .raw   (btn_raw),
    .level (btn_level),
    .pulse (btn_pulse)
  );

  // A button already held at request time must be released before it can confirm.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE:       if (in_req) state_nxt = btn_level[0] ? WAIT_REL : WAIT_PRESS;
      WAIT_REL: begin
        if (!in_req)           state_nxt = IDLE;
        else if (!btn_level[0]) state_nxt = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (btn_pulse[0]) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (!in_req) begin
          state_nxt = IDLE;
        end
      end
      DONE:       if (!in_req) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ack  <= 1'b0;
      in_data <= '0;
    end else begin
      in_ack <= capture;
      if (capture) in_data <= sw;
    end
  end

  assign stall = in_req & (state != DONE);
endmodule

// File: tb/tb_input_sequencer.sv
// Bench for input_sequencer: directed vector table, hand sequences, then random vs. a reference model.

module tb_input_sequencer;
  localparam int N_BTN = 4, DATA_W = 16, TICK_DIV = 4, STABLE_CNT = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N_BTN-1:0]  btn_raw = '0;
  logic [DATA_W-1:0] sw = '0;
  logic              in_req = 1'b0;
  logic              stall, in_ack;
  logic [DATA_W-1:0] in_data;
  logic [N_BTN-1:0]  btn_level, btn_pulse;

  int total = 0, passed = 0;
  bit ack_seen, stall_low, seen;

  always #5 clk = ~clk;

  input_sequencer #(.N_BTN(N_BTN), .DATA_W(DATA_W), .TICK_DIV(TICK_DIV), .STABLE_CNT(STABLE_CNT)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw(sw), .in_req(in_req), .stall(stall),
    .in_ack(in_ack), .in_data(in_data), .btn_level(btn_level), .btn_pulse(btn_pulse)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Poll a level or pulse bit until it reaches val, recording acks and stall drops on the way.
  task automatic wait_bit(input bit use_pulse, input int idx, input logic val, input string nm);
    logic cur;
    cur = 1'bx;
    ack_seen = 0;
    stall_low = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      cur = use_pulse ? btn_pulse[idx] : btn_level[idx];
      if (in_ack) ack_seen = 1;
      if (!stall) stall_low = 1;
      if (cur === val) break;
    end
    chk(nm, 64'(cur), 64'(val));
  endtask

  // Reference model: tick from a free cycle count, debounce as a run length of differing samples,
  // handshake as a set of phase flags.
  int                m_cyc;
  int                m_run [N_BTN];
  logic [N_BTN-1:0]  m_s1, m_s2, m_lev, m_pul;
  bit                m_wrel, m_wpress, m_done, m_ack;
  logic [DATA_W-1:0] m_data;

  task automatic model_step();
    bit tk;
    if (rst) begin
      m_cyc = 0; m_s1 = '0; m_s2 = '0; m_lev = '0; m_pul = '0;
      for (int i = 0; i < N_BTN; i++) m_run[i] = 0;
      m_wrel = 0; m_wpress = 0; m_done = 0; m_ack = 0; m_data = '0;
      return;
    end
    tk = (m_cyc % TICK_DIV) == TICK_DIV - 1;
    m_cyc++;
    m_ack = 0;
    if (m_done) begin
      if (!in_req) m_done = 0;
    end else if (m_wpress) begin
      if (m_pul[0]) begin m_ack = 1; m_data = sw; m_wpress = 0; m_done = 1; end
      else if (!in_req) m_wpress = 0;
    end else if (m_wrel) begin
      if (!in_req) m_wrel = 0;
      else if (!m_lev[0]) begin m_wrel = 0; m_wpress = 1; end
    end else if (in_req) begin
      if (m_lev[0]) m_wrel = 1; else m_wpress = 1;
    end
    m_pul = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (tk) begin
        if (m_s2[i] == m_lev[i]) m_run[i] = 0;
        else if (m_run[i] + 1 == STABLE_CNT) begin
          m_lev[i] = m_s2[i]; m_pul[i] = m_s2[i]; m_run[i] = 0;
        end else m_run[i]++;
      end
    end
    m_s2 = m_s1;
    m_s1 = btn_raw;
  endtask

  typedef struct {
    logic rst; logic req; logic [3:0] btn; logic [15:0] sw; int ncyc;
    logic [3:0] lev; logic [3:0] pul; logic ack; logic stall; logic [15:0] data;
  } vec_t;

  vec_t vt [13];

  initial begin
    //          rst   req   btn   sw        n   lev   pul   ack   stall data
    vt[0]  = '{1'b1, 1'b0, 4'h0, 16'h0000, 2,  4'h0, 4'h0, 1'b0, 1'b0, 16'h0000};
    vt[1]  = '{1'b0, 1'b0, 4'h2, 16'h0000, 11, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000};
    vt[2]  = '{1'b0, 1'b0, 4'h2, 16'h0000, 1,  4'h2, 4'h2, 1'b0, 1'b0, 16'h0000};
    vt[3]  = '{1'b0, 1'b0, 4'h2, 16'h0000, 1,  4'h2, 4'h0, 1'b0, 1'b0, 16'h0000};
    vt[4]  = '{1'b0, 1'b0, 4'h0, 16'h0000, 10, 4'h2, 4'h0, 1'b0, 1'b0, 16'h0000};
    vt[5]  = '{1'b0, 1'b0, 4'h0, 16'h0000, 1,  4'h0, 4'h0, 1'b0, 1'b0, 16'h0000};
    vt[6]  = '{1'b0, 1'b1, 4'h0, 16'hBEEF, 0,  4'h0, 4'h0, 1'b0, 1'b1, 16'h0000};
    vt[7]  = '{1'b0, 1'b1, 4'h1, 16'hBEEF, 12, 4'h1, 4'h1, 1'b0, 1'b1, 16'h0000};
    vt[8]  = '{1'b0, 1'b1, 4'h1, 16'hBEEF, 1,  4'h1, 4'h0, 1'b1, 1'b0, 16'hBEEF};
    vt[9]  = '{1'b0, 1'b1, 4'h1, 16'hBEEF, 1,  4'h1, 4'h0, 1'b0, 1'b0, 16'hBEEF};
    vt[10] = '{1'b0, 1'b0, 4'h1, 16'hBEEF, 1,  4'h1, 4'h0, 1'b0, 1'b0, 16'hBEEF};
    vt[11] = '{1'b0, 1'b1, 4'h1, 16'hBEEF, 0,  4'h1, 4'h0, 1'b0, 1'b1, 16'hBEEF};
    vt[12] = '{1'b0, 1'b1, 4'h1, 16'h1234, 8,  4'h1, 4'h0, 1'b0, 1'b1, 16'hBEEF};

    for (int k = 0; k < 13; k++) begin
      rst = vt[k].rst; in_req = vt[k].req; btn_raw = vt[k].btn; sw = vt[k].sw;
      #1;
      repeat (vt[k].ncyc) @(posedge clk);
      if (vt[k].ncyc > 0) @(negedge clk);
      chk($sformatf("vec%0d", k), 64'({btn_level, btn_pulse, in_ack, stall, in_data}),
          64'({vt[k].lev, vt[k].pul, vt[k].ack, vt[k].stall, vt[k].data}));
    end

    // Held-at-request: release, then re-press with a new switch word.
    btn_raw[0] = 1'b0;
    wait_bit(0, 0, 1'b0, "s4_release");
    chk("s4_no_ack_on_release", 64'(ack_seen), 64'(0));
    sw = 16'hCAFE;
    btn_raw[0] = 1'b1;
    wait_bit(1, 0, 1'b1, "s4_repress_pulse");
    chk("s4_no_early_ack", 64'(ack_seen), 64'(0));
    chk("s4_stall_held", 64'(stall_low), 64'(0));
    @(negedge clk);
    chk("s4_ack", 64'(in_ack), 64'(1));
    chk("s4_data", 64'(in_data), 64'(16'hCAFE));
    chk("s4_stall_drop", 64'(stall), 64'(0));
    @(negedge clk);
    chk("s4_ack_one_cycle", 64'(in_ack), 64'(0));
    in_req = 1'b0; btn_raw[0] = 1'b0;
    wait_bit(0, 0, 1'b0, "s4_cleanup");

    // Abort from WAIT_PRESS, then a press that must not be acknowledged.
    in_req = 1'b1;
    @(negedge clk); @(negedge clk);
    in_req = 1'b0;
    #1 chk("s5_abort_stall", 64'(stall), 64'(0));
    btn_raw[0] = 1'b1;
    wait_bit(1, 0, 1'b1, "s5_pulse");
    @(negedge clk);
    chk("s5_no_ack", 64'(ack_seen | in_ack), 64'(0));
    chk("s5_data_kept", 64'(in_data), 64'(16'hCAFE));
    btn_raw[0] = 1'b0;
    wait_bit(0, 0, 1'b0, "s5_release");
    btn_raw[3] = 1'b1;
    wait_bit(0, 3, 1'b1, "s5_b3_level");
    in_req = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b1; in_req = 1'b0;
    @(negedge clk);
    chk("s5_reset", 64'({btn_level, btn_pulse, in_ack, stall, in_data}), 64'(0));
    rst = 1'b0; btn_raw = '0;

    // Independence: button 3 during a pending input.
    in_req = 1'b1; btn_raw[3] = 1'b1;
    wait_bit(1, 3, 1'b1, "s6_b3_pulse");
    chk("s6_no_ack", 64'(ack_seen | in_ack), 64'(0));
    chk("s6_stall_held", 64'(stall_low), 64'(0));
    chk("s6_stall_now", 64'(stall), 64'(1));
    @(negedge clk);
    chk("s6_no_ack_after", 64'(in_ack), 64'(0));
    in_req = 1'b0; btn_raw[3] = 1'b0;
    wait_bit(0, 3, 1'b0, "s6_b3_release");

    // Bounce rejection on button 2.
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      btn_raw[2] = (((c / 5) % 2) == 0);
      @(negedge clk);
      if (btn_level[2] || btn_pulse[2]) seen = 1;
    end
    btn_raw[2] = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (btn_level[2] || btn_pulse[2]) seen = 1;
    end
    chk("s2_bounce_rejected", 64'(seen), 64'(0));

    // Random stimulus against the reference model, checked every cycle.
    rst = 1'b1; in_req = 1'b0; btn_raw = '0;
    @(posedge clk); model_step(); @(negedge clk);
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 799) == 0);
      for (int i = 0; i < N_BTN; i++)
        if ($urandom_range(0, 29) == 0) btn_raw[i] = ~btn_raw[i];
      if (!in_req) begin
        if ($urandom_range(0, 19) == 0) in_req = 1'b1;
        else sw = 16'($urandom);
      end else if (m_done) begin
        if ($urandom_range(0, 3) == 0) in_req = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        in_req = 1'b0;
      end
      #1;
      chk($sformatf("rnd%0d", c), 64'({btn_level, btn_pulse, in_ack, stall, in_data}),
          64'({m_lev, m_pul, m_ack, in_req & ~m_done, m_data}));
      @(posedge clk); model_step(); @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/input_sequencer.md
# input_sequencer

Front-end controller for the processor's push-button and switch inputs. It produces a shared sample tick, synchronizes and debounces up to N_BTN buttons, and emits one-cycle press pulses. It also sequences the processor's input instruction: it stalls the core until the confirm button (btn_raw[0]) is pressed, then latches the switch word and acknowledges. It sits between the board I/O pins and the processor's input port / stall logic.

## Interface
- N_BTN, 4: number of buttons; bit 0 is the confirm button
- DATA_W, 16: switch word width
- TICK_DIV, 250000: sample-tick period in clk cycles (≥2)
- STABLE_CNT, 3: consecutive differing tick samples required to change a debounced level (≥1)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- btn_raw  in  N_BTN  asynchronous raw button inputs
- sw  in  DATA_W  switch word (treated as static while a capture is pending)
- in_req  in  1  processor executing an input instruction; level signal, held until in_ack
- stall  out  1  combinational; freezes the processor while an input is pending
- in_ack  out  1  one-cycle pulse; in_data is valid
- in_data  out  DATA_W  captured switch word; holds its value until the next capture
- btn_level  out  N_BTN  debounced button levels
- btn_pulse  out  N_BTN  one-cycle rising-edge pulses of btn_level

## Operation
- **Synchronizer:** two-FF chain per button on clk, reset to 0.
- **Tick counter:** counts 0..TICK_DIV-1 and wraps. tick=1 for one cycle when count==TICK_DIV-1.
- **Debounce, per button i, evaluated only on tick** (s = synchronized sample, L = btn_level[i], cnt = per-button counter of width clog2(STABLE_CNT+1)):
  - s==L: cnt←0.
  - s!=L and cnt==STABLE_CNT-1: L←s, cnt←0.
  - else: cnt←cnt+1.
  - A sample matching L anywhere in the run restarts the count. Rising and falling transitions are treated symmetrically.
- **btn_pulse[i]:** registered. It is 1 exactly in the first cycle that btn_level[i] reads 1 after a 0→1 change. No pulse on falling edges.
- **FSM states:** IDLE, WAIT_REL, WAIT_PRESS, DONE.
  - IDLE: on in_req=1, go to WAIT_REL if btn_level[0]=1, else WAIT_PRESS.
  - WAIT_REL: go to WAIT_PRESS when btn_level[0]=0. This keeps a button already held at request time from confirming.
  - WAIT_PRESS: on btn_pulse[0]=1, in_data←sw, in_ack←1, go to DONE.
  - DONE: in_ack=1 only in the first DONE cycle. Go to IDLE when in_req=0.
  - Abort: in_req=0 in WAIT_REL or WAIT_PRESS returns to IDLE with no ack and no in_data change.
- **stall** = in_req & (state==IDLE | state==WAIT_REL | state==WAIT_PRESS). It is 0 in DONE.
- Buttons 1..N_BTN-1 only drive btn_level/btn_pulse; they never affect the FSM.

## Timing
- **Reset values:** stall=0 (given in_req=0), in_ack=0, in_data=0, btn_level=0, btn_pulse=0, tick count=0, all cnt=0, synchronizers=0, state IDLE.
- Reset asserted mid-operation aborts any pending input with no ack. The debounce state is cleared.
- **First tick:** the TICK_DIV-th cycle after rst deasserts. Subsequent ticks every TICK_DIV cycles.
- **Raw-to-level latency:** 2 cycles of synchronization, then the STABLE_CNT-th consecutive differing tick. btn_level and btn_pulse update on the clk edge following that tick.
- **Pulse-to-ack latency:** in_ack and the new in_data appear exactly 1 cycle after btn_pulse[0]. stall drops in the same cycle as in_ack.
- **Request-to-stall latency:** stall rises combinationally in the same cycle in_req rises.
- **Simultaneous events:**
  - btn_pulse[0] in the cycle the FSM enters WAIT_PRESS from IDLE is not seen, because WAIT_PRESS is not yet the current state.
  - in_req falling in the same cycle as btn_pulse[0] in WAIT_PRESS: the capture takes priority, then the FSM proceeds to DONE and on to IDLE.
- **Counter wrap:** the tick counter wraps to 0 on the tick cycle. cnt never exceeds STABLE_CNT-1.

## Test plan
All scenarios use TICK_DIV=4, STABLE_CNT=3.

1. **Clean press.** Reset, then btn_raw[1]=1 held. Expect btn_level[1]=1 after the third tick following the synchronized edge, btn_pulse[1] high for exactly 1 cycle, and btn_level[1]=0 three ticks after release with no pulse.
2. **Bounce rejection.** btn_raw[2] toggles every 5 cycles for 60 cycles, then stays 0. Expect btn_level[2]=0 and btn_pulse[2]=0 throughout.
3. **Input handshake.** sw=16'hBEEF, raise in_req with btn_level[0]=0. Expect stall=1 the same cycle. Press button 0: expect in_ack=1 for 1 cycle, one cycle after btn_pulse[0], with in_data=16'hBEEF and stall=0. Drop in_req: expect return to IDLE.
4. **Held button at request.** Button 0 is held before in_req rises. Expect no ack until release and re-press. in_data captures the sw value present at the re-press pulse.
5. **Abort and reset.** Lower in_req while in WAIT_PRESS: expect stall=0, no in_ack, in_data unchanged. Separately, assert rst mid-WAIT_PRESS: expect all outputs at reset values on the next cycle.
6. **Independence.** Press button 3 while in WAIT_PRESS. Expect btn_pulse[3], no in_ack, and stall still 1.
